// File: rtl/rpi_bus_tx_if.sv
// rpi_bus_tx_if: fabric write port, status and RPI strobe signals of the bus transmit path
interface rpi_bus_tx_if #(parameter int FIFO_DEPTH = 16);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic          bus_clk;
  logic          bus_rnw;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [CW-1:0] fifo_count;
  logic          underflow;
  logic          clr_flags;
  logic [15:0]   tx_count;
  modport slave (
    input  bus_clk, bus_rnw, wr_data, wr_valid, clr_flags,
    output wr_ready, fifo_count, underflow, tx_count
  );
  modport master (
    output bus_clk, bus_rnw, wr_data, wr_valid, clr_flags,
    input  wr_ready, fifo_count, underflow, tx_count
  );
endinterface

// File: rtl/rpi_bus_tx.sv
// rpi_bus_tx: FIFO-backed FPGA-to-RPI read path driving the shared 8-bit bus pins
module rpi_bus_tx #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] IDLE_BYTE  = 8'hEE
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  rpi_bus_tx_if.slave bus,
  inout  wire  [7:0]  bus_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, PRIME, PRESENT, WAIT_LOW} state_t;
  state_t        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          clk_m_q, clk_s_q, clk_p_q, rnw_m_q, rnw_s_q;
  logic [7:0]    bus_data_out_q;
  logic          head_valid_q, underflow_q, underflow_d;
  logic [15:0]   tx_count_q;
  logic          empty, push, pop, rise;
  assign empty          = count_q == '0;
  assign bus.wr_ready   = count_q < (AW+1)'(FIFO_DEPTH);
  assign push           = bus.wr_valid & bus.wr_ready;
  assign rise           = clk_s_q & ~clk_p_q;
  assign pop            = (state_q == PRESENT) & rnw_s_q & rise & head_valid_q;
  assign count_d        = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign underflow_d    = ((state_q == PRESENT) & rnw_s_q & rise & ~head_valid_q) | (underflow_q & ~bus.clr_flags);
  assign bus.fifo_count = count_q;
  assign bus.underflow  = underflow_q;
  assign bus.tx_count   = tx_count_q;
  assign bus_data       = bus.bus_rnw ? bus_data_out_q : 8'bz;
  // Two-flop synchronizers for the RPI strobe and direction, plus strobe history for edge detect
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      {clk_m_q, clk_s_q, clk_p_q, rnw_m_q, rnw_s_q} <= '0;
    end else begin
      clk_m_q <= bus.bus_clk;
      clk_s_q <= clk_m_q;
      clk_p_q <= clk_s_q;
      rnw_m_q <= bus.bus_rnw;
      rnw_s_q <= rnw_m_q;
    end
  end
  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk_100mhz) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end
  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_d;
    end
  end
  // Read FSM: latch the head in PRIME, pop only a byte the RPI actually saw
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      bus_data_out_q <= 8'h00;
      head_valid_q   <= 1'b0;
      underflow_q    <= 1'b0;
      tx_count_q     <= '0;
    end else begin
      underflow_q <= underflow_d;
      if (pop) tx_count_q <= tx_count_q + 16'd1;
      case (state_q)
        IDLE:     if (rnw_s_q) state_q <= PRIME;
        PRIME: begin
          bus_data_out_q <= empty ? IDLE_BYTE : mem_q[rd_ptr_q];
          head_valid_q   <= ~empty;
          state_q        <= PRESENT;
        end
        PRESENT:  state_q <= !rnw_s_q ? IDLE : rise ? WAIT_LOW : PRESENT;
        WAIT_LOW: state_q <= !rnw_s_q ? IDLE : !clk_s_q ? PRIME : WAIT_LOW;
      endcase
    end
  end
endmodule
